// File: rtl/sram_arbiter_2p.sv
// rtl/sram_arbiter_2p.sv - two-requester arbiter and sequencer for an 8x32 single-port D-FF SRAM
module sram_arbiter_2p #(
    parameter int ADDR_W     = 3,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_rdata,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_rdata,

    output logic [ADDR_W-1:0] sram_add,
    output logic              sram_we,
    output logic [DATA_W-1:0] sram_wd,
    input  logic [DATA_W-1:0] sram_rd
);

    logic              inflight0_q, inflight0_d;
    logic              inflight1_q, inflight1_d;
    logic              rsp0_valid_q, rsp0_valid_d;
    logic              rsp1_valid_q, rsp1_valid_d;
    logic [DATA_W-1:0] rsp0_rdata_q, rsp0_rdata_d;
    logic [DATA_W-1:0] rsp1_rdata_q, rsp1_rdata_d;
    logic              ptr_q, ptr_d;

    logic elig0, elig1;
    logic pick0;
    logic gnt0, gnt1;

    // A requester may have only one read outstanding, counting an unconsumed response.
    always_comb begin
        elig0 = req0_valid & (req0_we | (~inflight0_q & ~rsp0_valid_q));
        elig1 = req1_valid & (req1_we | (~inflight1_q & ~rsp1_valid_q));
        pick0 = (FIXED_PRIO != 0) ? 1'b1 : ~ptr_q;
        gnt0  = resetn & elig0 & (~elig1 | pick0);
        gnt1  = resetn & elig1 & (~elig0 | ~pick0);
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_comb begin
        sram_add = '0;
        sram_we  = 1'b0;
        sram_wd  = '0;
        if (gnt0) begin
            sram_add = req0_addr;
            sram_we  = req0_we;
            sram_wd  = req0_wdata;
        end else if (gnt1) begin
            sram_add = req1_addr;
            sram_we  = req1_we;
            sram_wd  = req1_wdata;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (FIXED_PRIO == 0) begin
            if (gnt0) begin
                ptr_d = 1'b1;
            end else if (gnt1) begin
                ptr_d = 1'b0;
            end
        end
    end

    // An in-flight read lasts exactly one cycle: the SRAM data is captured the cycle after grant.
    always_comb begin
        inflight0_d  = gnt0 & ~req0_we;
        inflight1_d  = gnt1 & ~req1_we;
        rsp0_valid_d = inflight0_q | (rsp0_valid_q & ~rsp0_ready);
        rsp1_valid_d = inflight1_q | (rsp1_valid_q & ~rsp1_ready);
        rsp0_rdata_d = inflight0_q ? sram_rd : rsp0_rdata_q;
        rsp1_rdata_d = inflight1_q ? sram_rd : rsp1_rdata_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inflight0_q  <= 1'b0;
            inflight1_q  <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
            ptr_q        <= 1'b0;
        end else begin
            inflight0_q  <= inflight0_d;
            inflight1_q  <= inflight1_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_rdata_q <= rsp1_rdata_d;
            ptr_q        <= ptr_d;
        end
    end

    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_rdata = rsp0_rdata_q;
    assign rsp1_rdata = rsp1_rdata_q;

endmodule

// File: tb/tb_sram_arbiter_2p.sv
// tb/tb_sram_arbiter_2p.sv - self-checking bench for sram_arbiter_2p with an SRAM and reference model
module tb_sram_arbiter_2p;
    localparam int AW = 3;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic          cv[2];
    logic          cwe[2];
    logic [AW-1:0] ca[2];
    logic [DW-1:0] cwd[2];
    logic          crr[2];

    logic          r_ready0, r_ready1, r_rv0, r_rv1;
    logic [DW-1:0] r_rd0, r_rd1;
    logic [AW-1:0] s_add;
    logic          s_we;
    logic [DW-1:0] s_wd, s_rd;

    logic          f_ready0, f_ready1, f_rv0, f_rv1;
    logic [DW-1:0] f_rd0, f_rd1;
    logic [AW-1:0] f_add;
    logic          f_we;
    logic [DW-1:0] f_wd;
    logic [DW-1:0] f_rd;
    assign f_rd = '0;

    logic          rdy[2];
    logic          rv[2];
    logic [DW-1:0] rdat[2];
    assign rdy[0] = r_ready0;
    assign rdy[1] = r_ready1;
    assign rv[0] = r_rv0;
    assign rv[1] = r_rv1;
    assign rdat[0] = r_rd0;
    assign rdat[1] = r_rd1;

    sram_arbiter_2p #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .resetn(resetn),
        .req0_valid(cv[0]), .req0_ready(r_ready0), .req0_we(cwe[0]), .req0_addr(ca[0]), .req0_wdata(cwd[0]),
        .rsp0_valid(r_rv0), .rsp0_ready(crr[0]), .rsp0_rdata(r_rd0),
        .req1_valid(cv[1]), .req1_ready(r_ready1), .req1_we(cwe[1]), .req1_addr(ca[1]), .req1_wdata(cwd[1]),
        .rsp1_valid(r_rv1), .rsp1_ready(crr[1]), .rsp1_rdata(r_rd1),
        .sram_add(s_add), .sram_we(s_we), .sram_wd(s_wd), .sram_rd(s_rd)
    );

    sram_arbiter_2p #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .resetn(resetn),
        .req0_valid(cv[0]), .req0_ready(f_ready0), .req0_we(cwe[0]), .req0_addr(ca[0]), .req0_wdata(cwd[0]),
        .rsp0_valid(f_rv0), .rsp0_ready(crr[0]), .rsp0_rdata(f_rd0),
        .req1_valid(cv[1]), .req1_ready(f_ready1), .req1_we(cwe[1]), .req1_addr(ca[1]), .req1_wdata(cwd[1]),
        .rsp1_valid(f_rv1), .rsp1_ready(crr[1]), .rsp1_rdata(f_rd1),
        .sram_add(f_add), .sram_we(f_we), .sram_wd(f_wd), .sram_rd(f_rd)
    );

    // D-FF SRAM: write on we, otherwise register the read address; read data is combinational.
    logic [DW-1:0] mem[8];
    logic [AW-1:0] areg;
    always @(posedge clk) begin
        if (s_we) mem[s_add] <= s_wd;
        else areg <= s_add;
    end
    assign s_rd = mem[areg];

    // A valid command that was not accepted must be presented unchanged next cycle.
    logic [AW+DW:0] snap[2];
    logic           hold[2];
    always @(posedge clk) begin
        for (int r = 0; r < 2; r++) begin
            if (hold[r] && resetn)
                assert (cv[r] && {cwe[r], ca[r], cwd[r]} == snap[r])
                else $error("command hold violated on requester %0d", r);
            hold[r] <= resetn && cv[r] && !rdy[r];
            snap[r] <= {cwe[r], ca[r], cwd[r]};
        end
    end

    // Reference model: memory image, one outstanding read per requester with a due cycle.
    int            cyc;
    bit            m_pend[2];
    int            m_due[2];
    logic [DW-1:0] m_pdata[2];
    bit            m_rv[2];
    logic [DW-1:0] m_rd[2];
    int            m_ptr;
    logic [DW-1:0] ref_mem[8];
    int            exp_g;
    int            passed = 0;
    int            total = 0;

    task automatic model_reset();
        for (int r = 0; r < 2; r++) begin
            m_pend[r] = 0;
            m_rv[r] = 0;
            m_rd[r] = '0;
        end
        m_ptr = 0;
    endtask

    task automatic eval_model();
        bit el[2];
        for (int r = 0; r < 2; r++) el[r] = cv[r] && (cwe[r] || (!m_pend[r] && !m_rv[r]));
        if (!resetn) exp_g = -1;
        else if (el[0] && el[1]) exp_g = m_ptr;
        else if (el[0]) exp_g = 0;
        else if (el[1]) exp_g = 1;
        else exp_g = -1;
    endtask

    task automatic model_tick();
        for (int r = 0; r < 2; r++) begin
            if (m_rv[r] && crr[r]) m_rv[r] = 0;
            if (m_pend[r] && m_due[r] == cyc) begin
                m_rv[r] = 1;
                m_rd[r] = m_pdata[r];
                m_pend[r] = 0;
            end
        end
        if (exp_g >= 0) begin
            if (cwe[exp_g]) ref_mem[ca[exp_g]] = cwd[exp_g];
            else begin
                m_pend[exp_g] = 1;
                m_due[exp_g] = cyc + 1;
                m_pdata[exp_g] = ref_mem[ca[exp_g]];
            end
            m_ptr = 1 - exp_g;
        end
        cyc++;
    endtask

    task automatic settle();
        @(negedge clk);
        eval_model();
    endtask

    task automatic advance();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic set_cmd(input int r, input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cv[r] = v;
        cwe[r] = we;
        ca[r] = a;
        cwd[r] = d;
    endtask

    function automatic logic [DW-1:0] pat(input int a);
        return 32'hA5C3_0000 + 32'(a) * 32'h1111;
    endfunction

    task automatic test_reset();
        set_cmd(0, 1'b1, 1'b1, 3'd3, 32'h1);
        set_cmd(1, 1'b1, 1'b1, 3'd4, 32'h2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (r_ready0 !== 1'b0) $display("FAIL reset_ready0: got %b want 0", r_ready0); else passed++;
        total++; if (r_ready1 !== 1'b0) $display("FAIL reset_ready1: got %b want 0", r_ready1); else passed++;
        total++; if (s_we !== 1'b0) $display("FAIL reset_sram_we: got %b want 0", s_we); else passed++;
        total++; if (s_add !== 3'd0 || s_wd !== 32'd0) $display("FAIL reset_sram_bus: got %h/%h want 0/0", s_add, s_wd); else passed++;
        total++; if ({r_rv0, r_rv1} !== 2'b00) $display("FAIL reset_rsp_valid: got %b want 00", {r_rv0, r_rv1}); else passed++;
        total++; if (r_rd0 !== 32'd0 || r_rd1 !== 32'd0) $display("FAIL reset_rdata: got %h/%h want 0/0", r_rd0, r_rd1); else passed++;
        total++; if ({f_ready0, f_ready1, f_we, f_rv0, f_rv1} !== 5'b0) $display("FAIL reset_fp_outs: got %b want 0", {f_ready0, f_ready1, f_we, f_rv0, f_rv1}); else passed++;
        total++; if (f_add !== 3'd0 || f_wd !== 32'd0 || f_rd0 !== 32'd0 || f_rd1 !== 32'd0) $display("FAIL reset_fp_data: got %h %h %h %h want 0", f_add, f_wd, f_rd0, f_rd1); else passed++;
        cv[0] = 1'b0;
        cv[1] = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        model_reset();
        cyc = 0;
    endtask

    task automatic test_write_read();
        crr[0] = 1'b1;
        set_cmd(0, 1'b1, 1'b1, 3'd3, 32'hDEADBEEF);
        settle();
        total++; if (r_ready0 !== 1'b1 || r_ready1 !== 1'b0) $display("FAIL wr_ready: got %b%b want 10", r_ready0, r_ready1); else passed++;
        total++; if (s_we !== 1'b1 || s_add !== 3'd3 || s_wd !== 32'hDEADBEEF) $display("FAIL wr_sram: got we=%b add=%0d wd=%h want 1/3/deadbeef", s_we, s_add, s_wd); else passed++;
        advance();
        set_cmd(0, 1'b1, 1'b0, 3'd3, 32'h0);
        settle();
        total++; if (r_ready0 !== 1'b1 || s_we !== 1'b0 || s_add !== 3'd3) $display("FAIL rd_grant: got rdy=%b we=%b add=%0d want 1/0/3", r_ready0, s_we, s_add); else passed++;
        advance();
        cv[0] = 1'b0;
        settle();
        total++; if (r_rv0 !== 1'b0) $display("FAIL rd_early: got %b want 0", r_rv0); else passed++;
        advance();
        settle();
        total++; if (r_rv0 !== 1'b1 || r_rd0 !== 32'hDEADBEEF) $display("FAIL rd_data: got v=%b d=%h want 1/deadbeef", r_rv0, r_rd0); else passed++;
        advance();
        settle();
        total++; if (r_rv0 !== 1'b0) $display("FAIL rd_consumed: got %b want 0", r_rv0); else passed++;
        advance();
    endtask

    task automatic test_rr_alternate();
        int g;
        int prev;
        g = -1;
        prev = -1;
        set_cmd(0, 1'b1, 1'b1, 3'd1, 32'h1000_0001);
        set_cmd(1, 1'b1, 1'b1, 3'd6, 32'h6000_0006);
        for (int i = 0; i < 6; i++) begin
            settle();
            g = exp_g;
            total++; if (r_ready0 !== (exp_g == 0) || r_ready1 !== (exp_g == 1)) $display("FAIL rr_grant[%0d]: got %b%b want g=%0d", i, r_ready0, r_ready1, exp_g); else passed++;
            if (prev >= 0) begin
                total++; if (rdy[prev] !== 1'b0) $display("FAIL rr_alternate[%0d]: requester %0d granted twice in a row", i, prev); else passed++;
            end
            prev = r_ready0 ? 0 : (r_ready1 ? 1 : -1);
            total++; if (f_ready0 !== 1'b1 || f_ready1 !== 1'b0 || f_add !== 3'd1) $display("FAIL fp_grant[%0d]: got %b%b add=%0d want 10/1", i, f_ready0, f_ready1, f_add); else passed++;
            advance();
        end
        if (g >= 0) cv[g] = 1'b0;
        settle();
        advance();
        cv[0] = 1'b0;
        cv[1] = 1'b0;
    endtask

    task automatic test_backpressure();
        crr[1] = 1'b1;
        set_cmd(1, 1'b1, 1'b1, 3'd5, 32'h5);
        settle();
        advance();
        crr[1] = 1'b0;
        set_cmd(1, 1'b1, 1'b0, 3'd5, 32'h0);
        settle();
        total++; if (r_ready1 !== 1'b1) $display("FAIL bp_first_read: got %b want 1", r_ready1); else passed++;
        advance();
        cv[1] = 1'b0;
        settle();
        advance();
        set_cmd(1, 1'b1, 1'b1, 3'd7, 32'h77);
        for (int i = 0; i < 4; i++) begin
            settle();
            total++; if (r_rv1 !== 1'b1 || r_rd1 !== 32'h5) $display("FAIL bp_hold[%0d]: got v=%b d=%h want 1/5", i, r_rv1, r_rd1); else passed++;
            if (i == 0) begin
                total++; if (r_ready1 !== 1'b1) $display("FAIL bp_write_ok: got %b want 1", r_ready1); else passed++;
            end else begin
                total++; if (r_ready1 !== 1'b0) $display("FAIL bp_read_blocked[%0d]: got %b want 0", i, r_ready1); else passed++;
            end
            advance();
            if (i == 0) set_cmd(1, 1'b1, 1'b0, 3'd5, 32'h0);
        end
        crr[1] = 1'b1;
        settle();
        total++; if (r_rv1 !== 1'b1 || r_ready1 !== 1'b0) $display("FAIL bp_release: got v=%b rdy=%b want 1/0", r_rv1, r_ready1); else passed++;
        advance();
        settle();
        total++; if (r_rv1 !== 1'b0 || r_ready1 !== 1'b1) $display("FAIL bp_regrant: got v=%b rdy=%b want 0/1", r_rv1, r_ready1); else passed++;
        advance();
        cv[1] = 1'b0;
        settle();
        advance();
        settle();
        total++; if (r_rv1 !== 1'b1 || r_rd1 !== 32'h5) $display("FAIL bp_second: got v=%b d=%h want 1/5", r_rv1, r_rd1); else passed++;
        advance();
        settle();
        advance();
    endtask

    task automatic test_hazard();
        crr[0] = 1'b1;
        set_cmd(0, 1'b1, 1'b1, 3'd2, 32'h11);
        settle();
        advance();
        cv[0] = 1'b0;
        settle();
        advance();
        set_cmd(0, 1'b1, 1'b0, 3'd2, 32'h0);
        settle();
        total++; if (r_ready0 !== 1'b1) $display("FAIL hz_read_grant: got %b want 1", r_ready0); else passed++;
        advance();
        cv[0] = 1'b0;
        set_cmd(1, 1'b1, 1'b1, 3'd2, 32'h22);
        settle();
        total++; if (r_ready1 !== 1'b1 || s_we !== 1'b1 || s_add !== 3'd2) $display("FAIL hz_write_grant: got rdy=%b we=%b add=%0d want 1/1/2", r_ready1, s_we, s_add); else passed++;
        advance();
        cv[1] = 1'b0;
        settle();
        total++; if (r_rv0 !== 1'b1 || r_rd0 !== 32'h11) $display("FAIL hz_old_data: got v=%b d=%h want 1/11", r_rv0, r_rd0); else passed++;
        advance();
        settle();
        advance();
        set_cmd(0, 1'b1, 1'b0, 3'd2, 32'h0);
        settle();
        advance();
        cv[0] = 1'b0;
        settle();
        advance();
        settle();
        total++; if (r_rv0 !== 1'b1 || r_rd0 !== 32'h22) $display("FAIL hz_new_data: got v=%b d=%h want 1/22", r_rv0, r_rd0); else passed++;
        advance();
        settle();
        advance();
    endtask

    task automatic test_all_addr();
        int idx[2];
        int nrsp[2];
        int gcyc[2][8];
        bit took[2];
        crr[0] = 1'b1;
        crr[1] = 1'b1;
        for (int a = 0; a < 8; a++) begin
            set_cmd(a % 2, 1'b1, 1'b1, 3'(a), pat(a));
            settle();
            total++; if (rdy[a % 2] !== 1'b1) $display("FAIL all_write[%0d]: got %b want 1", a, rdy[a % 2]); else passed++;
            advance();
            cv[a % 2] = 1'b0;
        end
        idx = '{0, 0};
        nrsp = '{0, 0};
        for (int k = 0; k < 80 && (nrsp[0] + nrsp[1]) < 16; k++) begin
            for (int r = 0; r < 2; r++)
                if (!cv[r] && idx[r] < 8) set_cmd(r, 1'b1, 1'b0, 3'(r == 0 ? idx[r] : 7 - idx[r]), 32'h0);
            settle();
            for (int r = 0; r < 2; r++) begin
                took[r] = (rdy[r] === 1'b1);
                if (took[r] && idx[r] < 8) gcyc[r][idx[r]] = cyc;
                if (rv[r] === 1'b1 && nrsp[r] < 8) begin
                    total++; if (rdat[r] !== pat(r == 0 ? nrsp[r] : 7 - nrsp[r])) $display("FAIL all_data[%0d][%0d]: got %h want %h", r, nrsp[r], rdat[r], pat(r == 0 ? nrsp[r] : 7 - nrsp[r])); else passed++;
                    total++; if (cyc - gcyc[r][nrsp[r]] != 2) $display("FAIL all_latency[%0d][%0d]: got %0d want 2", r, nrsp[r], cyc - gcyc[r][nrsp[r]]); else passed++;
                    nrsp[r]++;
                end
            end
            advance();
            for (int r = 0; r < 2; r++)
                if (took[r] && cv[r]) begin
                    cv[r] = 1'b0;
                    idx[r]++;
                end
        end
        total++; if (nrsp[0] != 8 || nrsp[1] != 8) $display("FAIL all_count: got %0d/%0d want 8/8", nrsp[0], nrsp[1]); else passed++;
        cv[0] = 1'b0;
        cv[1] = 1'b0;
        settle();
        advance();
    endtask

    task automatic test_reset_inflight();
        crr[0] = 1'b1;
        set_cmd(0, 1'b1, 1'b0, 3'd3, 32'h0);
        settle();
        total++; if (r_ready0 !== 1'b1) $display("FAIL rst_read_grant: got %b want 1", r_ready0); else passed++;
        advance();
        cv[0] = 1'b0;
        resetn = 1'b0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            settle();
            total++; if (r_rv0 !== 1'b0) $display("FAIL rst_in_reset[%0d]: got %b want 0", i, r_rv0); else passed++;
            advance();
        end
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            total++; if (r_rv0 !== 1'b0 || r_rd0 !== 32'h0) $display("FAIL rst_discard[%0d]: got v=%b d=%h want 0/0", i, r_rv0, r_rd0); else passed++;
            advance();
        end
        set_cmd(0, 1'b1, 1'b1, 3'd4, 32'h44);
        set_cmd(1, 1'b1, 1'b1, 3'd5, 32'h55);
        settle();
        total++; if (r_ready0 !== 1'b1 || r_ready1 !== 1'b0) $display("FAIL rst_ptr: got %b%b want 10", r_ready0, r_ready1); else passed++;
        advance();
        cv[0] = 1'b0;
        settle();
        advance();
        cv[1] = 1'b0;
        set_cmd(0, 1'b1, 1'b0, 3'd4, 32'h0);
        settle();
        advance();
        cv[0] = 1'b0;
        settle();
        advance();
        settle();
        total++; if (r_rv0 !== 1'b1 || r_rd0 !== 32'h44) $display("FAIL rst_fresh_read: got v=%b d=%h want 1/44", r_rv0, r_rd0); else passed++;
        advance();
        settle();
        advance();
    endtask

    task automatic test_random();
        int g;
        logic          ew;
        logic [AW-1:0] eadd;
        logic [DW-1:0] ewd;
        for (int k = 0; k < 400; k++) begin
            for (int r = 0; r < 2; r++) begin
                if (!cv[r] && $urandom_range(0, 3) != 0)
                    set_cmd(r, 1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom);
                crr[r] = ($urandom_range(0, 3) != 0);
            end
            settle();
            g = exp_g;
            ew = (g >= 0) ? cwe[g] : 1'b0;
            eadd = (g >= 0) ? ca[g] : '0;
            ewd = (g >= 0) ? cwd[g] : '0;
            total++; if (r_ready0 !== (g == 0) || r_ready1 !== (g == 1)) $display("FAIL rnd_grant[%0d]: got %b%b want g=%0d", k, r_ready0, r_ready1, g); else passed++;
            total++; if (s_we !== ew || s_add !== eadd || s_wd !== ewd) $display("FAIL rnd_sram[%0d]: got %b/%0d/%h want %b/%0d/%h", k, s_we, s_add, s_wd, ew, eadd, ewd); else passed++;
            total++; if (r_rv0 !== m_rv[0] || r_rd0 !== m_rd[0]) $display("FAIL rnd_rsp0[%0d]: got %b/%h want %b/%h", k, r_rv0, r_rd0, m_rv[0], m_rd[0]); else passed++;
            total++; if (r_rv1 !== m_rv[1] || r_rd1 !== m_rd[1]) $display("FAIL rnd_rsp1[%0d]: got %b/%h want %b/%h", k, r_rv1, r_rd1, m_rv[1], m_rd[1]); else passed++;
            advance();
            if (g >= 0) cv[g] = 1'b0;
        end
    endtask

    initial begin
        for (int r = 0; r < 2; r++) begin
            set_cmd(r, 1'b0, 1'b0, '0, '0);
            crr[r] = 1'b0;
            hold[r] = 1'b0;
        end
        cyc = 0;
        exp_g = -1;
        model_reset();
        test_reset();
        test_write_read();
        test_rr_alternate();
        test_backpressure();
        test_hazard();
        test_all_addr();
        test_reset_inflight();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
